sseg_page_scheduler: RTL

//  Bus-master sequencer for the 8-digit seven-segment LED mux slot core. Holds NUM_PAGES
//  64-bit display pages written by the CPU over its own slot interface. Rotates pages by

---
 rtl/sseg_sched_pkg.sv | 24 ++
 rtl/sseg_sched_regs.sv | 90 +++++++++
 rtl/sseg_page_scheduler.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/sseg_sched_pkg.sv
// Shared types and register map for the seven-segment page scheduler.
// The blink option is enabled by defining SSEG_SCHED_BLINK_EN.
package sseg_sched_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_D0     = 3'd1,
        WR_D1     = 3'd2,
        DWELL     = 3'd3,
        URG_HOLD  = 3'd4,
        WR_BLANK0 = 3'd5,
        WR_BLANK1 = 3'd6
    } state_t;

    localparam logic [4:0]  CTRL_ADDR  = 5'd16;
    localparam logic [4:0]  DWELL_ADDR = 5'd17;
    localparam logic [4:0]  STAT_ADDR  = 5'd18;
    localparam logic [31:0] BLANK_WORD = 32'hFFFF_FFFF;

    function automatic logic [2:0] next_page_idx(input logic [2:0] cur, input logic [2:0] last);
        return (cur == last) ? 3'd0 : cur + 3'd1;
    endfunction

endpackage

// File: rtl/sseg_sched_regs.sv
// CPU-visible register file of the page scheduler: display pages, CTRL, DWELL and read mux.
// CTRL.BLINK exists only when SSEG_SCHED_BLINK_EN is defined.
module sseg_sched_regs
    import sseg_sched_pkg::*;
#(
    parameter int NUM_PAGES = 4,
    parameter int DWELL_W   = 32,
    parameter int DWELL_DEF = 100_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cs,
    input  logic               write,
    input  logic [4:0]         addr,
    input  logic [31:0]        wr_data,
    input  logic [6:0]         status,
    input  logic [2:0]         page_sel,
    output logic [31:0]        rd_data,
    output logic [31:0]        page_lo,
    output logic [31:0]        page_hi,
    output logic               en,
    output logic               blink,
    output logic [DWELL_W-1:0] dwell
);

    logic [31:0] lo_q [NUM_PAGES];
    logic [31:0] hi_q [NUM_PAGES];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NUM_PAGES; p++) begin
                lo_q[p] <= BLANK_WORD;
                hi_q[p] <= BLANK_WORD;
            end
            en    <= 1'b0;
            dwell <= DWELL_W'(DWELL_DEF);
        end else if (cs && write) begin
            for (int p = 0; p < NUM_PAGES; p++) begin
                if (addr == 5'(2 * p))
                    lo_q[p] <= wr_data;
                if (addr == 5'(2 * p + 1))
                    hi_q[p] <= wr_data;
            end
            if (addr == CTRL_ADDR)
                en <= wr_data[0];
            if (addr == DWELL_ADDR)
                dwell <= DWELL_W'(wr_data);
        end
    end

`ifdef SSEG_SCHED_BLINK_EN
    always_ff @(posedge clk) begin
        if (reset)
            blink <= 1'b0;
        else if (cs && write && addr == CTRL_ADDR)
            blink <= wr_data[1];
    end
`else
    assign blink = 1'b0;
`endif

    always_comb begin
        page_lo = lo_q[0];
        page_hi = hi_q[0];
        for (int p = 0; p < NUM_PAGES; p++) begin
            if (page_sel == 3'(p)) begin
                page_lo = lo_q[p];
                page_hi = hi_q[p];
            end
        end
    end

    // Reads are purely combinational on addr; anything not decoded returns zero.
    always_comb begin
        rd_data = '0;
        for (int p = 0; p < NUM_PAGES; p++) begin
            if (addr == 5'(2 * p))
                rd_data = lo_q[p];
            if (addr == 5'(2 * p + 1))
                rd_data = hi_q[p];
        end
        case (addr)
            CTRL_ADDR:  rd_data = {30'd0, blink, en};
            DWELL_ADDR: rd_data = 32'(dwell);
            STAT_ADDR:  rd_data = {25'd0, status};
            default:    ;
        endcase
    end

endmodule

// File: rtl/sseg_page_scheduler.sv
// Bus-master sequencer rotating display pages into the seven-segment LED mux core, with urgent override.
// Define SSEG_SCHED_BLINK_EN to blank each page for the second half of its dwell when CTRL.BLINK=1.
module sseg_page_scheduler
    import sseg_sched_pkg::*;
#(
    parameter int NUM_PAGES = 4,
    parameter int DWELL_W   = 32,
    parameter int DWELL_DEF = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic        read,
    input  logic        write,
    input  logic [4:0]  addr,
    input  logic [31:0] wr_data,
    output logic [31:0] rd_data,
    output logic        m_cs,
    output logic        m_write,
    output logic [4:0]  m_addr,
    output logic [31:0] m_wr_data,
    input  logic        urg_req,
    input  logic [63:0] urg_data,
    output logic        urg_ack
);

    localparam logic [2:0] LAST_PAGE = 3'(NUM_PAGES - 1);

    state_t             state;
    logic [2:0]         cur_page;
    logic [2:0]         next_page;
    logic [2:0]         page_sel;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [DWELL_W-1:0] dwell;
    logic [DWELL_W-1:0] dwell_eff;
    logic               urg_active;
    logic [31:0]        urg_hi_q;
    logic [31:0]        page_lo;
    logic [31:0]        page_hi;
    logic               en;
    logic               blink;
    logic [6:0]         status;
    logic               unused_read;

    assign unused_read = read;
    assign next_page   = next_page_idx(cur_page, LAST_PAGE);
    assign dwell_eff   = (dwell == '0) ? DWELL_W'(1) : dwell;
    assign status      = {cur_page, urg_active, state};

    // On the expiry cycle the first write already belongs to the next page.
    assign page_sel = (state == DWELL && dwell_cnt == '0) ? next_page : cur_page;

`ifdef SSEG_SCHED_BLINK_EN
    logic [DWELL_W-1:0] blank_at;
`else
    logic unused_blink;
    assign unused_blink = blink;
`endif

    sseg_sched_regs #(
        .NUM_PAGES (NUM_PAGES),
        .DWELL_W   (DWELL_W),
        .DWELL_DEF (DWELL_DEF)
    ) u_regs (
        .clk      (clk),
        .reset    (reset),
        .cs       (cs),
        .write    (write),
        .addr     (addr),
        .wr_data  (wr_data),
        .status   (status),
        .page_sel (page_sel),
        .rd_data  (rd_data),
        .page_lo  (page_lo),
        .page_hi  (page_hi),
        .en       (en),
        .blink    (blink),
        .dwell    (dwell)
    );

    // Master outputs are registered together with the state, so WR_D0/WR_D1 cycles carry the bus write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cur_page   <= 3'd0;
            dwell_cnt  <= '0;
            urg_active <= 1'b0;
            urg_hi_q   <= '0;
            urg_ack    <= 1'b0;
            m_cs       <= 1'b0;
            m_write    <= 1'b0;
            m_addr     <= 5'd0;
            m_wr_data  <= '0;
`ifdef SSEG_SCHED_BLINK_EN
            blank_at   <= '0;
`endif
        end else begin
            m_cs    <= 1'b0;
            m_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (urg_req) begin
                        state      <= WR_D0;
                        urg_active <= 1'b1;
                        urg_hi_q   <= urg_data[63:32];
                        m_cs       <= 1'b1;
                        m_write    <= 1'b1;
                        m_addr     <= 5'd0;
                        m_wr_data  <= urg_data[31:0];
                    end else if (en) begin
                        state     <= WR_D0;
                        m_cs      <= 1'b1;
                        m_write   <= 1'b1;
                        m_addr    <= 5'd0;
                        m_wr_data <= page_lo;
                    end
                end
                WR_D0: begin
                    state     <= WR_D1;
                    m_cs      <= 1'b1;
                    m_write   <= 1'b1;
                    m_addr    <= 5'd1;
                    m_wr_data <= urg_active ? urg_hi_q : page_hi;
                end
                WR_D1: begin
                    if (urg_active) begin
                        state   <= URG_HOLD;
                        urg_ack <= 1'b1;
                    end else if (urg_req) begin
                        state      <= WR_D0;
                        urg_active <= 1'b1;
                        urg_hi_q   <= urg_data[63:32];
                        m_cs       <= 1'b1;
                        m_write    <= 1'b1;
                        m_addr     <= 5'd0;
                        m_wr_data  <= urg_data[31:0];
                    end else begin
                        state     <= DWELL;
                        dwell_cnt <= dwell_eff - DWELL_W'(1);
`ifdef SSEG_SCHED_BLINK_EN
                        blank_at  <= dwell_eff >> 1;
`endif
                    end
                end
                DWELL: begin
                    if (urg_req) begin
                        state      <= WR_D0;
                        urg_active <= 1'b1;
                        urg_hi_q   <= urg_data[63:32];
                        m_cs       <= 1'b1;
                        m_write    <= 1'b1;
                        m_addr     <= 5'd0;
                        m_wr_data  <= urg_data[31:0];
                    end else if (!en) begin
                        state <= IDLE;
                    end else if (dwell_cnt == '0) begin
                        state     <= WR_D0;
                        cur_page  <= next_page;
                        m_cs      <= 1'b1;
                        m_write   <= 1'b1;
                        m_addr    <= 5'd0;
                        m_wr_data <= page_lo;
`ifdef SSEG_SCHED_BLINK_EN
                    end else if (blink && dwell_cnt == blank_at) begin
                        state     <= WR_BLANK0;
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                        m_cs      <= 1'b1;
                        m_write   <= 1'b1;
                        m_addr    <= 5'd0;
                        m_wr_data <= BLANK_WORD;
`endif
                    end else begin
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                    end
                end
`ifdef SSEG_SCHED_BLINK_EN
                // The dwell count keeps running through the blank pair so the period length is unchanged.
                WR_BLANK0: begin
                    state     <= WR_BLANK1;
                    m_cs      <= 1'b1;
                    m_write   <= 1'b1;
                    m_addr    <= 5'd1;
                    m_wr_data <= BLANK_WORD;
                    if (dwell_cnt != '0)
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                end
                WR_BLANK1: begin
                    state <= DWELL;
                    if (dwell_cnt != '0)
                        dwell_cnt <= dwell_cnt - DWELL_W'(1);
                end
`endif
                URG_HOLD: begin
                    if (!urg_req) begin
                        urg_ack    <= 1'b0;
                        urg_active <= 1'b0;
                        if (en) begin
                            state     <= WR_D0;
                            m_cs      <= 1'b1;
                            m_write   <= 1'b1;
                            m_addr    <= 5'd0;
                            m_wr_data <= page_lo;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
